// File: rtl/pipe_defs_pkg.sv
// rtl/pipe_defs_pkg.sv - shared pipeline widths, constants, payload and state types
package pipe_defs_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [DATA_W-1:0] ZERO_WORD    = '0;
    localparam logic [ADDR_W-1:0] NOP_REG_ADDR = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] wd;
        logic              wreg;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
        logic              whilo;
    } wb_payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/mem_wb_skid_if.sv
// rtl/mem_wb_skid_if.sv - MEM to WB handshake bundle with flush and occupancy
interface mem_wb_skid_if
    import pipe_defs_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ADDR_W
);
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_wd;
    logic          in_wreg;
    logic [DW-1:0] in_wdata;
    logic [DW-1:0] in_hi;
    logic [DW-1:0] in_lo;
    logic          in_whilo;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_wd;
    logic          out_wreg;
    logic [DW-1:0] out_wdata;
    logic [DW-1:0] out_hi;
    logic [DW-1:0] out_lo;
    logic          out_whilo;
    logic [1:0]    occupancy;

    modport master (
        output flush, in_valid, in_wd, in_wreg, in_wdata, in_hi, in_lo, in_whilo, out_ready,
        input  in_ready, out_valid, out_wd, out_wreg, out_wdata, out_hi, out_lo, out_whilo, occupancy
    );

    modport slave (
        input  flush, in_valid, in_wd, in_wreg, in_wdata, in_hi, in_lo, in_whilo, out_ready,
        output in_ready, out_valid, out_wd, out_wreg, out_wdata, out_hi, out_lo, out_whilo, occupancy
    );
endinterface

// File: rtl/wb_payload_reg.sv
// rtl/wb_payload_reg.sv - load-enabled payload register with synchronous clear
module wb_payload_reg
    import pipe_defs_pkg::*;
#(
    parameter type      payload_t = wb_payload_t,
    parameter payload_t CLR_VAL   = '0
) (
    input  logic     clk,
    input  logic     clr,
    input  logic     load,
    input  payload_t d,
    output payload_t q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= CLR_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_wb_skid.sv
// rtl/mem_wb_skid.sv - MEM to WB stage with two-entry skid buffer, flush and occupancy
module mem_wb_skid
    import pipe_defs_pkg::*;
#(
    parameter int DATA_W = pipe_defs_pkg::DATA_W,
    parameter int ADDR_W = pipe_defs_pkg::ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    mem_wb_skid_if.slave  bus
);

    typedef struct packed {
        logic [ADDR_W-1:0] wd;
        logic              wreg;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
        logic              whilo;
    } payload_t;

    localparam payload_t RST_VAL = '{
        wd:    ADDR_W'(NOP_REG_ADDR),
        wreg:  1'b0,
        wdata: DATA_W'(ZERO_WORD),
        hi:    DATA_W'(ZERO_WORD),
        lo:    DATA_W'(ZERO_WORD),
        whilo: 1'b0
    };

    skid_state_t state_q, state_d;
    logic        in_ready_q, out_valid_q;
    logic [1:0]  occ_q;
    logic        push, pop;
    logic        load_main, load_skid, main_from_skid, clr;
    payload_t    in_pl, main_d, main_q, skid_q;

    assign push  = bus.in_valid & in_ready_q;
    assign pop   = out_valid_q & bus.out_ready;
    assign clr   = rst | bus.flush;
    assign in_pl = '{wd: bus.in_wd, wreg: bus.in_wreg, wdata: bus.in_wdata,
                     hi: bus.in_hi, lo: bus.in_lo, whilo: bus.in_whilo};

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (bus.flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d   = ONE;
                        load_main = 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        load_main = 1'b1;
                    end else if (push) begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d        = ONE;
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_q : in_pl;

    // Handshake flags are registered from the next state so in_ready never sees out_ready combinationally
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
            occ_q       <= (state_d == FULL) ? 2'd2 : (state_d == ONE) ? 2'd1 : 2'd0;
        end
    end

    wb_payload_reg #(.payload_t(payload_t), .CLR_VAL(RST_VAL)) u_main (
        .clk  (clk),
        .clr  (clr),
        .load (load_main),
        .d    (main_d),
        .q    (main_q)
    );

    wb_payload_reg #(.payload_t(payload_t), .CLR_VAL(RST_VAL)) u_skid (
        .clk  (clk),
        .clr  (clr),
        .load (load_skid),
        .d    (in_pl),
        .q    (skid_q)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.occupancy = occ_q;
    assign bus.out_wd    = main_q.wd;
    assign bus.out_wdata = main_q.wdata;
    assign bus.out_hi    = main_q.hi;
    assign bus.out_lo    = main_q.lo;
    // Enables are masked so WB can use them directly
    assign bus.out_wreg  = main_q.wreg & out_valid_q;
    assign bus.out_whilo = main_q.whilo & out_valid_q;

endmodule

// File: tb/tb_mem_wb_skid.sv
// tb/tb_mem_wb_skid.sv - scoreboard bench for mem_wb_skid
module tb_mem_wb_skid;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mon_en = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_pop = 0;
    int   n0;
    logic [127:0] sb_q[$];

    mem_wb_skid_if #(.DW(32), .AW(5)) bus ();

    mem_wb_skid #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [127:0] pk(input logic [4:0] wd, input logic wreg,
                                        input logic [31:0] wdata, input logic [31:0] hi,
                                        input logic [31:0] lo, input logic whilo);
        return {25'd0, wd, wreg, wdata, hi, lo, whilo};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [4:0] wd, input logic wreg,
                       input logic [31:0] wdata, input logic [31:0] hi,
                       input logic [31:0] lo, input logic whilo);
        bus.in_valid = v;
        bus.in_wd    = wd;
        bus.in_wreg  = wreg;
        bus.in_wdata = wdata;
        bus.in_hi    = hi;
        bus.in_lo    = lo;
        bus.in_whilo = whilo;
    endtask

    // Scoreboard: sampled mid-cycle, when inputs and registered outputs are both stable
    always @(negedge clk) begin
        if (mon_en) begin
            automatic int  sz = sb_q.size();
            automatic logic do_pop  = (sz > 0) && bus.out_ready;
            automatic logic do_push = bus.in_valid && (sz < 2);
            chk("occ", 128'(bus.occupancy), 128'(sz));
            chk("in_ready", 128'(bus.in_ready), 128'(sz < 2));
            chk("out_valid", 128'(bus.out_valid), 128'(sz > 0));
            if (sz > 0) begin
                chk("payload", pk(bus.out_wd, bus.out_wreg, bus.out_wdata, bus.out_hi,
                                  bus.out_lo, bus.out_whilo), sb_q[0]);
            end else begin
                chk("mask", 128'({bus.out_wreg, bus.out_whilo}), 128'(0));
            end
            if (rst || bus.flush) begin
                sb_q.delete();
            end else begin
                if (do_pop) begin
                    void'(sb_q.pop_front());
                    n_pop++;
                end
                if (do_push) begin
                    sb_q.push_back(pk(bus.in_wd, bus.in_wreg, bus.in_wdata, bus.in_hi,
                                      bus.in_lo, bus.in_whilo));
                end
            end
        end
    end

    initial begin
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        put(0, 0, 0, 0, 0, 0, 0);

        tick();
        tick();
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
        chk("rst_occ", 128'(bus.occupancy), 128'(0));
        chk("rst_payload", pk(bus.out_wd, bus.out_wreg, bus.out_wdata, bus.out_hi,
                              bus.out_lo, bus.out_whilo), 128'(0));
        rst    = 1'b0;
        mon_en = 1'b1;

        put(1, 5, 1, 32'hDEADBEEF, 0, 0, 0);
        tick();
        put(0, 0, 0, 0, 0, 0, 0);
        chk("first_valid", 128'(bus.out_valid), 128'(1));
        chk("first_wd", 128'(bus.out_wd), 128'(5));
        chk("first_wdata", 128'(bus.out_wdata), 128'(32'hDEADBEEF));
        tick();

        for (int i = 1; i <= 8; i++) begin
            put(1, 5'(i), 1, 32'(i), 0, 0, 0);
            tick();
            chk("stream_wdata", 128'(bus.out_wdata), 128'(i));
            chk("stream_occ", 128'(bus.occupancy), 128'(1));
        end
        put(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("stream_drained", 128'(bus.out_valid), 128'(0));

        n0 = n_pop;
        bus.out_ready = 1'b0;
        put(1, 1, 1, 32'h11, 0, 0, 0);
        tick();
        put(1, 2, 1, 32'h22, 0, 0, 0);
        tick();
        put(1, 3, 1, 32'h33, 0, 0, 0);
        chk("bp_in_ready", 128'(bus.in_ready), 128'(0));
        chk("bp_occ", 128'(bus.occupancy), 128'(2));
        chk("bp_hold_a", 128'(bus.out_wdata), 128'(32'h11));
        tick();
        chk("bp_still_a", 128'(bus.out_wdata), 128'(32'h11));
        chk("bp_c_refused", 128'(bus.occupancy), 128'(2));
        bus.out_ready = 1'b1;
        tick();
        chk("bp_b_next", 128'(bus.out_wdata), 128'(32'h22));
        tick();
        put(0, 0, 0, 0, 0, 0, 0);
        chk("bp_c_next", 128'(bus.out_wdata), 128'(32'h33));
        tick();
        chk("bp_count", 128'(n_pop - n0), 128'(3));

        bus.out_ready = 1'b0;
        put(1, 4, 1, 32'h44, 0, 0, 0);
        tick();
        put(1, 6, 1, 32'h55, 32'h1, 32'h2, 1);
        tick();
        put(1, 7, 1, 32'h66, 0, 0, 0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        put(0, 0, 0, 0, 0, 0, 0);
        chk("flush_valid", 128'(bus.out_valid), 128'(0));
        chk("flush_wreg", 128'(bus.out_wreg), 128'(0));
        chk("flush_whilo", 128'(bus.out_whilo), 128'(0));
        chk("flush_occ", 128'(bus.occupancy), 128'(0));
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("flush_no_z", 128'(bus.out_valid), 128'(0));

        put(1, 3, 0, 32'h12, 32'hAAAA0000, 32'h0000BBBB, 1);
        tick();
        put(0, 0, 0, 0, 0, 0, 0);
        chk("hilo_whilo", 128'(bus.out_whilo), 128'(1));
        chk("hilo_wreg", 128'(bus.out_wreg), 128'(0));
        chk("hilo_hi", 128'(bus.out_hi), 128'(32'hAAAA0000));
        chk("hilo_lo", 128'(bus.out_lo), 128'(32'h0000BBBB));
        tick();
        chk("idle_whilo", 128'(bus.out_whilo), 128'(0));
        chk("idle_hi_kept", 128'(bus.out_hi), 128'(32'hAAAA0000));
        chk("idle_lo_kept", 128'(bus.out_lo), 128'(32'h0000BBBB));

        bus.out_ready = 1'b0;
        put(1, 8, 1, 32'hA1, 32'h3, 32'h4, 1);
        tick();
        put(1, 9, 1, 32'hA2, 0, 0, 0);
        tick();
        put(0, 0, 0, 0, 0, 0, 0);
        chk("pre_rst_occ", 128'(bus.occupancy), 128'(2));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_valid", 128'(bus.out_valid), 128'(0));
        chk("rst2_occ", 128'(bus.occupancy), 128'(0));
        chk("rst2_in_ready", 128'(bus.in_ready), 128'(1));
        chk("rst2_payload", pk(bus.out_wd, bus.out_wreg, bus.out_wdata, bus.out_hi,
                               bus.out_lo, bus.out_whilo), 128'(0));
        put(1, 9, 1, 32'h77, 0, 0, 0);
        tick();
        put(0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_push", 128'(bus.out_wdata), 128'(32'h77));
        chk("post_rst_valid", 128'(bus.out_valid), 128'(1));
        bus.out_ready = 1'b1;
        tick();

        for (int i = 0; i < 400; i++) begin
            put(1'($urandom_range(0, 1)), 5'($urandom), 1'($urandom), $urandom, $urandom,
                $urandom, 1'($urandom));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 19) == 0);
            tick();
        end
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        put(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        tick();
        chk("drain", 128'(sb_q.size()), 128'(0));
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_skid.md
# mem_wb_skid

Parametrised MEM→WB pipeline stage replacing the bare pass-through register. Carries the GPR write (address, enable, data) and HI/LO write (hi, lo, enable) from the memory stage to write-back. Uses a valid/ready handshake and a 2-entry skid buffer, so a write-back stall never drops or duplicates an instruction. Adds synchronous flush and an occupancy output.

## Interface
- `DATA_W`, 32, width of GPR data and of HI/LO
- `ADDR_W`, 5, width of GPR address
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `flush`  in  1  discard all buffered entries (exception/branch recovery)
- `in_valid`  in  1  MEM stage presents an instruction
- `in_ready`  out  1  stage can accept this cycle
- `in_wd`  in  ADDR_W  destination GPR
- `in_wreg`  in  1  GPR write enable
- `in_wdata`  in  DATA_W  GPR write data
- `in_hi`, `in_lo`  in  DATA_W  HI/LO write data
- `in_whilo`  in  1  HI/LO write enable
- `out_valid`  out  1  WB payload valid
- `out_ready`  in  1  WB consumes this cycle
- `out_wd`, `out_wreg`, `out_wdata`, `out_hi`, `out_lo`, `out_whilo`  out  as inputs  registered payload
- `occupancy`  out  2  entries held (0..2)

## Operation
- push = `in_valid & in_ready`; pop = `out_valid & out_ready`.
- Two entries, MAIN (drives outputs) and SKID. States:
  - EMPTY: push → ONE, MAIN loaded.
  - ONE: push&pop → ONE, MAIN reloaded. push&!pop → FULL, SKID loaded. pop&!push → EMPTY.
  - FULL: pop → ONE, MAIN takes SKID. No push is possible (`in_ready`=0).
- `in_ready` is registered. It is 1 in EMPTY/ONE and 0 in FULL, so there is no combinational path from `out_ready` to `in_ready`.
- `out_valid` = 1 in ONE/FULL. `occupancy` = 0/1/2 for EMPTY/ONE/FULL.
- Write-enable masking: `out_wreg` and `out_whilo` are forced to 0 whenever `out_valid`=0. WB can treat them as final enables without gating.
- Payload is held stable while `out_valid & !out_ready`.
- Flush: at the next edge the state becomes EMPTY and both entries are invalidated. A push in the same cycle is discarded. Flush has priority over push/pop.
- Reset has priority over flush and sets:
  - state EMPTY, `in_ready`=1, `out_valid`=0, `occupancy`=0;
  - `out_wd`=0 (NOP address), `out_wreg`=0, `out_wdata`/`out_hi`/`out_lo`=0, `out_whilo`=0.
- No width arithmetic; all payload fields are stored verbatim.

## Timing
- Latency: push at edge N → payload on outputs and `out_valid`=1 after edge N.
- Throughput: 1 per cycle while `out_ready`=1.
- Once `out_ready` drops, at most one further push is absorbed (into SKID). `in_ready` falls after the edge that fills SKID.
- Recovery from FULL: pop at edge N → `in_ready`=1 after edge N; new push possible at edge N+1.
- `rst` asserted mid-transfer drops buffered entries at the next edge. The first push is accepted at the first edge with `rst`=0.
- All outputs are register-driven; the only exception is the enable masking, which is a gate on registered `out_valid`.

## Structure
- Shared package `pipe_defs_pkg` holds:
  - default `DATA_W`/`ADDR_W`;
  - `ZERO_WORD` and `NOP_REG_ADDR` constants;
  - `wb_payload_t` struct (wd, wreg, wdata, hi, lo, whilo);
  - state enum {EMPTY, ONE, FULL}.
- One sub-module is natural: `wb_payload_reg`, a load-enabled `wb_payload_t` register with synchronous clear. It is instantiated twice (MAIN, SKID).

## Test plan
- Reset: hold `rst` for 2 cycles → all outputs 0, `in_ready`=1, `occupancy`=0. Release, push {wd=5, wreg=1, wdata=0xDEADBEEF} → next cycle `out_wd`=5, `out_wdata`=0xDEADBEEF, `out_valid`=1.
- Streaming: `out_ready`=1, push 8 back-to-back entries with wdata=1..8 → outputs show 1..8 on consecutive cycles, `occupancy` stays 1.
- Backpressure:
  - stimulus: drop `out_ready` while pushing A=0x11, B=0x22, C=0x33.
  - before release: A held on outputs, `occupancy`=2, `in_ready`=0, C not accepted.
  - after raising `out_ready`: order A, B, C with no loss or duplication.
- Flush in FULL with simultaneous push → next cycle `out_valid`=0, `out_wreg`=0, `out_whilo`=0, `occupancy`=0. The pushed entry never appears.
- HI/LO: push {whilo=1, hi=0xAAAA0000, lo=0x0000BBBB, wreg=0} → outputs match. During the idle cycle after the pop, `out_whilo`=0 even though `out_hi`/`out_lo` retain their values.
- Reset in FULL state → next cycle EMPTY, all outputs at reset values. A push in the first post-reset cycle is accepted.
